// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-write initiator.
package spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;

    // Peripheral register map
    localparam logic [ADDR_W-1:0] EN_OUT_LO = 7'h00;
    localparam logic [ADDR_W-1:0] EN_OUT_HI = 7'h01;
    localparam logic [ADDR_W-1:0] EN_PWM_LO = 7'h02;
    localparam logic [ADDR_W-1:0] EN_PWM_HI = 7'h03;
    localparam logic [ADDR_W-1:0] PWM_DUTY  = 7'h04;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_t;

    // Frame layout on the wire, MSB first: {write, addr, data}
    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic              write,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        return {write, addr, wdata};
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable 8-bit down-counter timing every phase of an SPI frame.
module spi_phase_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] count,
    output logic       zero
);

    // Load wins over counting; the counter parks at zero between phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator for 16-bit register-write frames with optional read-back.
//
// state | meaning
// IDLE  | nCS high, ready for a request
// SETUP | nCS low, sCLK low, first bit on COPI before the first rising edge
// HIGH  | sCLK high, COPI stable, CIPO sampled at the end of data-phase bits
// LOW   | sCLK low, COPI already moved to the next bit
// HOLD  | sCLK low after the last falling edge, nCS still low
// GAP   | nCS high, enforced inter-frame spacing; done in its last cycle
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int SETUP_CYCLES = 4,
    parameter int HOLD_CYCLES  = 4,
    parameter int GAP_CYCLES   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       sCLK,
    output logic       nCS,
    output logic       COPI,
    input  logic       CIPO
);

    if (CLK_DIV < 3 || CLK_DIV > 255 ||
        SETUP_CYCLES < 1 || SETUP_CYCLES > 255 ||
        HOLD_CYCLES < 1 || HOLD_CYCLES > 255 ||
        GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_param_check
        $error("spi_controller: timing parameter out of legal range");
    end

    // Timer reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [7:0] DIV_LD   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LD   = 8'(GAP_CYCLES - 1);

    state_t                  state, state_d;
    logic [FRAME_BITS-1:0]   shreg, shreg_d;
    logic                    wr_frame, wr_frame_d;
    logic [3:0]              bit_idx, bit_idx_d;
    logic [DATA_W-1:0]       cap, cap_d;
    logic                    cipo_s1, cipo_s2;

    logic                    sclk_d, ncs_d, copi_d, ready_d, done_d;
    logic [DATA_W-1:0]       rd_data_d;

    logic                    timer_load;
    logic [7:0]              timer_val;
    logic [7:0]              timer_count;
    logic                    timer_zero;

    spi_phase_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .count    (timer_count),
        .zero     (timer_zero)
    );

    // CIPO comes from another clock domain; two flops before it is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cipo_s1 <= 1'b0;
            cipo_s2 <= 1'b0;
        end else begin
            cipo_s1 <= CIPO;
            cipo_s2 <= cipo_s1;
        end
    end

    // State, datapath and every output are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            wr_frame  <= 1'b0;
            bit_idx   <= 4'd0;
            cap       <= '0;
            sCLK      <= 1'b0;
            nCS       <= 1'b1;
            COPI      <= 1'b0;
            req_ready <= 1'b1;
            done      <= 1'b0;
            rd_data   <= '0;
        end else begin
            state     <= state_d;
            shreg     <= shreg_d;
            wr_frame  <= wr_frame_d;
            bit_idx   <= bit_idx_d;
            cap       <= cap_d;
            sCLK      <= sclk_d;
            nCS       <= ncs_d;
            COPI      <= copi_d;
            req_ready <= ready_d;
            done      <= done_d;
            rd_data   <= rd_data_d;
        end
    end

    // Next-state and next-output logic; all phase ends are driven by the timer.
    always_comb begin
        state_d    = state;
        shreg_d    = shreg;
        wr_frame_d = wr_frame;
        bit_idx_d  = bit_idx;
        cap_d      = cap;
        sclk_d     = sCLK;
        ncs_d      = nCS;
        copi_d     = COPI;
        ready_d    = req_ready;
        done_d     = 1'b0;
        rd_data_d  = rd_data;
        timer_load = 1'b0;
        timer_val  = 8'd0;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    shreg_d    = pack_frame(req_write, req_addr, req_wdata);
                    wr_frame_d = req_write;
                    bit_idx_d  = 4'd15;
                    ncs_d      = 1'b0;
                    copi_d     = req_write;
                    ready_d    = 1'b0;
                    timer_load = 1'b1;
                    timer_val  = SETUP_LD;
                    state_d    = SETUP;
                end
            end

            SETUP: begin
                if (timer_zero) begin
                    sclk_d     = 1'b1;
                    timer_load = 1'b1;
                    timer_val  = DIV_LD;
                    state_d    = HIGH;
                end
            end

            HIGH: begin
                if (timer_zero) begin
                    // Data phase bits are sampled as late as possible in the high phase.
                    if (bit_idx <= 4'd7) begin
                        cap_d = {cap[DATA_W-2:0], cipo_s2};
                    end
                    sclk_d     = 1'b0;
                    timer_load = 1'b1;
                    if (bit_idx != 4'd0) begin
                        shreg_d   = shreg << 1;
                        copi_d    = shreg[FRAME_BITS-2];
                        bit_idx_d = bit_idx - 4'd1;
                        timer_val = DIV_LD;
                        state_d   = LOW;
                    end else begin
                        timer_val = HOLD_LD;
                        state_d   = HOLD;
                    end
                end
            end

            LOW: begin
                if (timer_zero) begin
                    sclk_d     = 1'b1;
                    timer_load = 1'b1;
                    timer_val  = DIV_LD;
                    state_d    = HIGH;
                end
            end

            HOLD: begin
                if (timer_zero) begin
                    ncs_d      = 1'b1;
                    copi_d     = 1'b0;
                    timer_load = 1'b1;
                    timer_val  = GAP_LD;
                    state_d    = GAP;
                    if (!wr_frame) begin
                        rd_data_d = cap;
                    end
                    // A one-cycle gap is also its own last cycle.
                    done_d = (GAP_CYCLES == 1);
                end
            end

            GAP: begin
                // Registered done must rise one cycle ahead of the final gap cycle.
                if (timer_count == 8'd1) begin
                    done_d = 1'b1;
                end
                if (timer_zero) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: a default-timing instance and a
// minimum-timing instance, each with a serial peripheral model on the wire.
module tb_spi_controller;
    import spi_pkg::*;

    typedef struct {
        logic [15:0] frame;
        logic [7:0]  rd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [inst %0d] at %0t: got 0x%0h, expected 0x%0h",
                     name, inst, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int CD = (g == 0) ? 4 : 3;
        localparam int SU = (g == 0) ? 4 : 1;
        localparam int HO = (g == 0) ? 4 : 1;
        localparam int GA = (g == 0) ? 8 : 1;
        localparam int LOW_EXP = SU + 31 * CD + HO;

        logic       rst_n;
        logic       req_valid, req_ready, req_write;
        logic [6:0] req_addr;
        logic [7:0] req_wdata;
        logic       done;
        logic [7:0] rd_data;
        logic       sCLK, nCS, COPI, CIPO;
        logic       fin = 1'b0;

        spi_controller #(
            .CLK_DIV(CD), .SETUP_CYCLES(SU), .HOLD_CYCLES(HO), .GAP_CYCLES(GA)
        ) dut (
            .clk(clk), .rst_n(rst_n),
            .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
            .req_addr(req_addr), .req_wdata(req_wdata),
            .done(done), .rd_data(rd_data),
            .sCLK(sCLK), .nCS(nCS), .COPI(COPI), .CIPO(CIPO)
        );

        // ---------------- peripheral model ----------------
        logic [15:0] pbits;
        int          pcnt = 0;
        int          tot_edges = 0;
        logic [15:0] last_frame;
        int          last_edges;
        logic [7:0]  pregs [128];
        logic [6:0]  rd_addr;

        always @(posedge sCLK or negedge nCS) begin
            if (sCLK) begin
                if (!nCS) begin
                    pbits = {pbits[14:0], COPI};
                    pcnt++;
                    tot_edges++;
                end
            end else begin
                pbits = 16'h0;
                pcnt  = 0;
            end
        end

        initial begin
            for (int i = 0; i < 128; i++) pregs[i] = 8'h00;
            forever begin
                @(posedge nCS);
                last_frame = pbits;
                last_edges = pcnt;
                if (pcnt == 16 && pbits[15]) pregs[pbits[14:8]] = pbits[7:0];
            end
        end

        initial begin
            logic [7:0] v;
            CIPO = 1'b0;
            rd_addr = 7'h0;
            forever begin
                @(negedge sCLK);
                if (!nCS && pcnt >= 8 && pcnt < 16) begin
                    if (pcnt == 8) rd_addr = pbits[6:0];
                    v = pregs[rd_addr];
                    CIPO = v[15 - pcnt];
                end else begin
                    CIPO = 1'($urandom);
                end
            end
        end

        // ---------------- reference model + scoreboard ----------------
        logic [7:0] ref_regs [128];
        logic [7:0] ref_rd = 8'h00;
        exp_t       sb [$];
        initial for (int i = 0; i < 128; i++) ref_regs[i] = 8'h00;

        // ---------------- monitor ----------------
        int low_cnt = 0, high_cnt = 0, last_low = 0, last_gap = 0;
        bit seen_frame = 0, prev_done = 0;

        always @(negedge clk) begin
            exp_t e;
            if (!rst_n) begin
                low_cnt = 0; high_cnt = 0; seen_frame = 0; prev_done = 0;
            end else begin
                if (!nCS) begin
                    if (high_cnt != 0 && seen_frame) begin
                        last_gap = high_cnt;
                        check("gap_min", g, 32'(high_cnt >= GA + 1), 1);
                    end
                    high_cnt = 0;
                    low_cnt++;
                end else begin
                    if (low_cnt != 0) begin
                        last_low = low_cnt;
                        seen_frame = 1;
                    end
                    low_cnt = 0;
                    high_cnt++;
                end
                if (prev_done) check("done_pulse_width", g, done, 0);
                if (done) begin
                    if (sb.size() == 0) begin
                        check("spurious_done", g, done, 0);
                    end else begin
                        e = sb.pop_front();
                        check("frame_bits", g, last_frame, e.frame);
                        check("sclk_edges", g, last_edges, 16);
                        check("ncs_low_cycles", g, last_low, LOW_EXP);
                        check("rd_data", g, rd_data, e.rd);
                        check("commit", g, pregs[e.frame[14:8]], ref_regs[e.frame[14:8]]);
                    end
                end
                prev_done = done;
            end
        end

        // ---------------- stimulus ----------------
        task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d,
                            input bit keep);
            exp_t e;
            bit   acc;
            int   n;
            @(negedge clk);
            req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
            acc = 0;
            n = 0;
            while (!acc && n < 3000) begin
                acc = req_ready;
                @(posedge clk);
                if (!acc) @(negedge clk);
                n++;
            end
            check("accept", g, 32'(acc), 1);
            if (acc) begin
                e.frame = {w, a, d};
                if (w) ref_regs[a] = d;
                else   ref_rd = ref_regs[a];
                e.rd = ref_rd;
                sb.push_back(e);
            end
            @(negedge clk);
            if (!keep) req_valid = 1'b0;
            req_write = 1'($urandom);
            req_addr  = 7'($urandom);
            req_wdata = 8'($urandom);
        endtask

        task automatic wait_idle();
            int n = 0;
            while ((sb.size() != 0 || !req_ready) && n < 3000) begin
                @(negedge clk);
                n++;
            end
            check("idle_reached", g, 32'(n < 3000), 1);
        endtask

        task automatic random_frames(input int cnt);
            logic       w;
            logic [6:0] a;
            logic [7:0] d;
            bit         keep;
            for (int i = 0; i < cnt; i++) begin
                w = 1'($urandom);
                a = (i % 2 == 1) ? 7'($urandom_range(0, 4)) : 7'($urandom);
                d = 8'($urandom);
                keep = (i != cnt - 1) && ($urandom_range(0, 3) == 0);
                send(w, a, d, keep);
                if (!keep) begin
                    repeat ($urandom_range(0, 20)) @(negedge clk);
                    wait_idle();
                end
            end
        endtask

        initial begin
            int n_busy;
            int e0;
            int n;
            rst_n = 1'b0;
            req_valid = 1'b0; req_write = 1'b0; req_addr = 7'h0; req_wdata = 8'h0;
            repeat (5) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check("rst_ncs", g, nCS, 1);
            check("rst_sclk", g, sCLK, 0);
            check("rst_copi", g, COPI, 0);
            check("rst_ready", g, req_ready, 1);
            check("rst_done", g, done, 0);
            check("rst_rd_data", g, rd_data, 8'h00);
            n_busy = 0;
            repeat (50) begin
                @(negedge clk);
                if (nCS !== 1'b1 || sCLK !== 1'b0 || COPI !== 1'b0 || done !== 1'b0 ||
                    req_ready !== 1'b1) n_busy++;
            end
            check("idle_quiet", g, n_busy, 0);

            if (g == 0) begin
                // single write to the duty register
                send(1'b1, PWM_DUTY, 8'hA5, 0);
                wait_idle();
                check("duty_reg", g, pregs[PWM_DUTY], 8'hA5);

                // two requests with valid held across the first frame
                e0 = tot_edges;
                send(1'b1, EN_OUT_LO, 8'($urandom), 1);
                send(1'b1, EN_PWM_LO, 8'($urandom), 0);
                wait_idle();
                check("b2b_edges", g, tot_edges - e0, 32);
                check("b2b_gap", g, last_gap, GA + 1);
                check("b2b_reg0", g, pregs[EN_OUT_LO], ref_regs[EN_OUT_LO]);
                check("b2b_reg2", g, pregs[EN_PWM_LO], ref_regs[EN_PWM_LO]);

                // read-back of a known value
                send(1'b1, EN_OUT_HI, 8'h3C, 0);
                wait_idle();
                send(1'b0, EN_OUT_HI, 8'($urandom), 0);
                wait_idle();
                check("read_first_bit", g, last_frame[15], 0);
                check("read_value", g, rd_data, 8'h3C);

                random_frames(12);

                // reset after the 10th rising edge of a frame
                @(negedge clk);
                req_valid = 1'b1; req_write = 1'b1; req_addr = EN_OUT_LO; req_wdata = 8'h77;
                n = 0;
                while (req_ready && n < 100) begin @(negedge clk); n++; end
                req_valid = 1'b0;
                n = 0;
                while (pcnt < 10 && n < 2000) begin @(negedge clk); n++; end
                check("abort_edges", g, pcnt, 10);
                rst_n = 1'b0;
                #1;
                check("abort_ncs", g, nCS, 1);
                check("abort_sclk", g, sCLK, 0);
                check("abort_copi", g, COPI, 0);
                check("abort_done", g, done, 0);
                check("abort_ready", g, req_ready, 1);
                ref_rd = 8'h00;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (20) @(negedge clk);
                check("abort_no_commit", g, pregs[EN_OUT_LO], ref_regs[EN_OUT_LO]);
                send(1'b1, EN_OUT_LO, 8'h5A, 0);
                wait_idle();
                check("post_abort_write", g, pregs[EN_OUT_LO], 8'h5A);
            end else begin
                // minimum timing: fill the whole register map
                for (int i = 0; i < 5; i++) begin
                    send(1'b1, 7'(i), 8'(8'h11 * (i + 1)), 0);
                    wait_idle();
                end
                for (int i = 0; i < 5; i++) check("fast_reg", g, pregs[i], 8'(8'h11 * (i + 1)));
                random_frames(8);
            end
            repeat (20) @(negedge clk);
            check("sb_drained", g, sb.size(), 0);
            fin = 1'b1;
        end
    end

    initial begin
        int n = 0;
        while (!(g_inst[0].fin && g_inst[1].fin) && n < 80000) begin
            @(posedge clk);
            n++;
        end
        check("global_finish", 0, 32'(g_inst[0].fin && g_inst[1].fin), 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
